// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the mem_responder32 data-memory responder.
//  - RISC-V exception codes returned on the load/store exception outputs
//  - access size encoding, FSM state encoding, latched request record
//  - helpers for exception checking and byte-lane alignment
package mem_responder_pkg;

  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2,
    SzBad  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef struct packed {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    size_e       size;
    logic        reserve;
    logic        cond;
  } req_t;

  // Returns {valid, code}. Alignment is checked before range.
  function automatic logic [4:0] check_exc(input logic        is_write,
                                           input logic [31:0] addr,
                                           input size_e       size,
                                           input logic [31:0] base,
                                           input logic [31:0] span);
    logic mis;
    logic oor;
    mis = ((size == SzHalf) && addr[0]) ||
          ((size == SzWord) && (addr[1:0] != 2'b00)) ||
          (size == SzBad);
    oor = (addr < base) || ((addr - base) >= span);
    if (mis) return {1'b1, is_write ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN};
    if (oor) return {1'b1, is_write ? EXC_STORE_FAULT : EXC_LOAD_FAULT};
    return 5'b0;
  endfunction

  function automatic logic [3:0] store_be(input size_e size, input logic [1:0] off);
    case (size)
      SzByte:  return 4'b0001 << off;
      SzHalf:  return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

  function automatic logic [31:0] load_data(input logic [31:0] word, input logic [1:0] off,
                                            input size_e size);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (size)
      SzByte:  return {24'b0, s[7:0]};
      SzHalf:  return {16'b0, s[15:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port Depth x 32 word array with per-byte write enables and a
// registered read. Contents are not reset.
//  clk_i    clock
//  en_i     access strobe (read always, write when we_i)
//  we_i     write enable
//  be_i     byte enables for writes
//  addr_i   word index
//  wdata_i  write data, already lane-aligned
//  rdata_o  read data, valid the cycle after an access
module mem_responder_array #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder32.sv
// Data-memory responder: target of the core's memRead/memWrite interface.
// Accepts one load or store at a time, waits LATENCY cycles, then returns
// load data or a store acknowledgement with a RISC-V exception code.
// Optional LR/SC reservation tracking is built when
// MEM_RESPONDER_RESERVATION_EN is defined.
//  clk, reset (async active-low)
//  in_read_*   : load request (enable, address, size, reserve)
//  in_write_*  : store request (enable, address, data, size, conditional)
//  out_busy    : request not accepted this cycle
//  out_read_*  : load response (valid pulse, data, reservation, exception)
//  out_write_* : store response (valid pulse, exception)
module mem_responder32
  import mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_read_enable,
  input  logic [31:0] in_read_address,
  input  logic [1:0]  in_read_size,
  input  logic        in_read_reserve,
  input  logic        in_write_enable,
  input  logic [31:0] in_write_address,
  input  logic [31:0] in_write_data,
  input  logic [1:0]  in_write_size,
  input  logic        in_write_conditional,
  output logic        out_busy,
  output logic        out_read_valid,
  output logic [31:0] out_read_data,
  output logic [1:0]  out_read_reservation,
  output logic [4:0]  out_read_exception,
  output logic        out_write_valid,
  output logic [4:0]  out_write_exception
);

  localparam int unsigned AddrW      = $clog2(DEPTH);
  localparam logic [31:0] Span       = 32'(DEPTH) * 32'd4;
  localparam int          WaitCycles = int'(LATENCY) - 1;
  localparam logic [15:0] WaitLast   = (WaitCycles > 0) ? 16'(WaitCycles - 1) : 16'd0;

  state_e      state_q;
  req_t        req_q;
  logic [15:0] cnt_q;
  logic        busy_q;
  logic        rd_valid_q, wr_valid_q;
  logic [31:0] rd_data_q;
  logic [4:0]  rd_exc_q, wr_exc_q;

  req_t        in_req, acc_req;
  logic        accept, go;
  logic [4:0]  acc_exc, resp_exc;
  logic        acc_ok, store_ok;
  logic [31:0] acc_off;
  logic [AddrW-1:0] acc_idx;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata, resp_data;

  // Write wins when both enables are high; the read stays pending at the core.
  always_comb begin
    in_req = '0;
    if (in_write_enable) begin
      in_req.is_write = 1'b1;
      in_req.addr     = in_write_address;
      in_req.wdata    = in_write_data;
      in_req.size     = size_e'(in_write_size);
      in_req.cond     = in_write_conditional;
    end else begin
      in_req.addr     = in_read_address;
      in_req.size     = size_e'(in_read_size);
      in_req.reserve  = in_read_reserve;
    end
  end

  assign accept  = (state_q == StIdle) && (in_read_enable || in_write_enable);
  // The array is touched on the edge entering RESP: straight from the inputs
  // when there is no wait, otherwise from the latched request on the last wait
  // cycle. Deferring the write keeps a mid-wait reset from committing a store.
  assign acc_req = (state_q == StIdle) ? in_req : req_q;
  assign go      = (LATENCY == 1) ? accept : ((state_q == StWait) && (cnt_q == WaitLast));

  assign acc_exc = check_exc(acc_req.is_write, acc_req.addr, acc_req.size, BASE_ADDR, Span);
  assign acc_ok  = !acc_exc[4];
  assign acc_off = acc_req.addr - BASE_ADDR;
  assign acc_idx = acc_off[AddrW+1:2];

  assign mem_en    = go && acc_ok;
  assign mem_we    = mem_en && acc_req.is_write && store_ok;
  assign mem_be    = store_be(acc_req.size, acc_req.addr[1:0]);
  assign mem_wdata = store_data(acc_req.wdata, acc_req.addr[1:0]);

  logic unused_off;
  assign unused_off = ^{acc_off[31:AddrW+2], acc_off[1:0]};

  mem_responder_array #(
    .Depth (DEPTH),
    .AddrW (AddrW)
  ) u_array (
    .clk_i   (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (acc_idx),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign resp_exc  = check_exc(req_q.is_write, req_q.addr, req_q.size, BASE_ADDR, Span);
  assign resp_data = resp_exc[4] ? 32'b0 : load_data(mem_rdata, req_q.addr[1:0], req_q.size);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      req_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_exc_q   <= '0;
      wr_exc_q   <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            req_q   <= in_req;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (LATENCY == 1) ? StResp : StWait;
          end
        end
        StWait: begin
          if (cnt_q == WaitLast) state_q <= StResp;
          else                   cnt_q   <= cnt_q + 16'd1;
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (req_q.is_write) begin
            wr_valid_q <= 1'b1;
            wr_exc_q   <= resp_exc;
          end else begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= resp_data;
            rd_exc_q   <= resp_exc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEM_RESPONDER_RESERVATION_EN
  logic             resv_valid_q;
  logic [AddrW-1:0] resv_idx_q;
  logic             sc_fail_q;
  logic [1:0]       resv_out_q;
  logic             resv_hit;

  assign resv_hit = resv_valid_q && (resv_idx_q == acc_idx);
  assign store_ok = !acc_req.cond || resv_hit;

  // Reservation state changes at the array access, so the response edge
  // already sees the post-access value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resv_valid_q <= 1'b0;
      resv_idx_q   <= '0;
      sc_fail_q    <= 1'b0;
    end else if (go) begin
      sc_fail_q <= 1'b0;
      if (acc_ok) begin
        if (!acc_req.is_write) begin
          if (acc_req.reserve) begin
            resv_valid_q <= 1'b1;
            resv_idx_q   <= acc_idx;
          end
        end else begin
          sc_fail_q <= !store_ok;
          if (store_ok && resv_hit) resv_valid_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 resv_out_q <= 2'b00;
    else if (state_q == StResp) resv_out_q <= {sc_fail_q, resv_valid_q};
  end

  assign out_read_reservation = resv_out_q;
`else
  logic unused_resv;
  assign unused_resv          = ^{acc_req.reserve, acc_req.cond};
  assign store_ok             = 1'b1;
  assign out_read_reservation = 2'b00;
`endif

  assign out_busy            = busy_q;
  assign out_read_valid      = rd_valid_q;
  assign out_read_data       = rd_data_q;
  assign out_read_exception  = rd_exc_q;
  assign out_write_valid     = wr_valid_q;
  assign out_write_exception = wr_exc_q;

endmodule

// File: tb/tb_mem_responder32.sv
module tb_mem_responder32;

  localparam int unsigned Lat = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_read_enable, in_read_reserve;
  logic [31:0] in_read_address;
  logic [1:0]  in_read_size;
  logic        in_write_enable, in_write_conditional;
  logic [31:0] in_write_address, in_write_data;
  logic [1:0]  in_write_size;
  logic        out_busy, out_read_valid, out_write_valid;
  logic [31:0] out_read_data;
  logic [1:0]  out_read_reservation;
  logic [4:0]  out_read_exception, out_write_exception;

  int checks = 0;
  int errors = 0;

  mem_responder32 #(
    .BASE_ADDR (32'h0000_1000),
    .DEPTH     (1024),
    .LATENCY   (Lat)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_read_enable       (in_read_enable),
    .in_read_address      (in_read_address),
    .in_read_size         (in_read_size),
    .in_read_reserve      (in_read_reserve),
    .in_write_enable      (in_write_enable),
    .in_write_address     (in_write_address),
    .in_write_data        (in_write_data),
    .in_write_size        (in_write_size),
    .in_write_conditional (in_write_conditional),
    .out_busy             (out_busy),
    .out_read_valid       (out_read_valid),
    .out_read_data        (out_read_data),
    .out_read_reservation (out_read_reservation),
    .out_read_exception   (out_read_exception),
    .out_write_valid      (out_write_valid),
    .out_write_exception  (out_write_exception)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                       input logic cond, output int lat, output logic [4:0] exc);
    in_write_address     = addr;
    in_write_data        = data;
    in_write_size        = size;
    in_write_conditional = cond;
    in_write_enable      = 1'b1;
    for (int n = 0; n < 50 && out_busy; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    in_write_enable      = 1'b0;
    in_write_conditional = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_write_valid) begin lat = k; break; end
    end
    exc = out_write_exception;
  endtask

  task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic resv,
                      output int lat, output logic [31:0] data, output logic [4:0] exc,
                      output logic [1:0] rsv);
    in_read_address = addr;
    in_read_size    = size;
    in_read_reserve = resv;
    in_read_enable  = 1'b1;
    for (int n = 0; n < 50 && out_busy; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    in_read_enable  = 1'b0;
    in_read_reserve = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_read_valid) begin lat = k; break; end
    end
    data = out_read_data;
    exc  = out_read_exception;
    rsv  = out_read_reservation;
  endtask

  int          lat, wlat, rlat;
  logic [31:0] rd;
  logic [4:0]  ex;
  logic [1:0]  rv;
  logic        busy_hi, early_r, seen_w;

  initial begin
    reset = 1'b0;
    in_read_enable = 0; in_read_address = 0; in_read_size = 0; in_read_reserve = 0;
    in_write_enable = 0; in_write_address = 0; in_write_data = 0; in_write_size = 0;
    in_write_conditional = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst busy", 32'(out_busy), 32'd0);
    check_eq("rst rvalid", 32'(out_read_valid), 32'd0);
    check_eq("rst wvalid", 32'(out_write_valid), 32'd0);
    check_eq("rst rdata", out_read_data, 32'd0);
    check_eq("rst rexc", 32'(out_read_exception), 32'd0);
    check_eq("rst wexc", 32'(out_write_exception), 32'd0);
    check_eq("rst resv", 32'(out_read_reservation), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Word store then load, latency checks
    store(32'h1000, 32'hDEAD_BEEF, 2'd2, 1'b0, lat, ex);
    check_eq("st word lat", 32'(lat), 32'(Lat));
    check_eq("st word exc", 32'(ex), 32'h0);
    load(32'h1000, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("ld word lat", 32'(lat), 32'(Lat));
    check_eq("ld word data", rd, 32'hDEAD_BEEF);
    check_eq("ld word exc", 32'(ex), 32'h0);

    // Byte store into top lane, then sub-word loads
    store(32'h1003, 32'h0000_00AA, 2'd0, 1'b0, lat, ex);
    check_eq("st byte exc", 32'(ex), 32'h0);
    load(32'h1000, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("ld merged", rd, 32'hAAAD_BEEF);
    load(32'h1003, 2'd0, 1'b0, lat, rd, ex, rv);
    check_eq("ld byte3", rd, 32'h0000_00AA);
    load(32'h1002, 2'd1, 1'b0, lat, rd, ex, rv);
    check_eq("ld half2", rd, 32'h0000_AAAD);
    load(32'h1000, 2'd1, 1'b0, lat, rd, ex, rv);
    check_eq("ld half0", rd, 32'h0000_BEEF);

    // Exceptions
    load(32'h1001, 2'd1, 1'b0, lat, rd, ex, rv);
    check_eq("ld misalign exc", 32'(ex), 32'h14);
    check_eq("ld misalign data", rd, 32'h0);
    store(32'h0FFC, 32'h1234_5678, 2'd2, 1'b0, lat, ex);
    check_eq("st below exc", 32'(ex), 32'h17);
    store(32'h1000, 32'h5555_5555, 2'd3, 1'b0, lat, ex);
    check_eq("st size3 exc", 32'(ex), 32'h16);
    load(32'h1000, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("mem unchanged", rd, 32'hAAAD_BEEF);
    load(32'h2000, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("ld above exc", 32'(ex), 32'h15);
    check_eq("ld above data", rd, 32'h0);
    store(32'h1FFC, 32'h1234_5678, 2'd2, 1'b0, lat, ex);
    check_eq("st last exc", 32'(ex), 32'h0);
    load(32'h1FFC, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("ld last data", rd, 32'h1234_5678);
    check_eq("ld last exc", 32'(ex), 32'h0);

    // Simultaneous read and write: write first, read after
    in_write_address = 32'h1008; in_write_data = 32'h1122_3344; in_write_size = 2'd2;
    in_read_address  = 32'h1000; in_read_size  = 2'd2;
    in_write_enable  = 1'b1;     in_read_enable = 1'b1;
    @(posedge clk); #1;
    in_write_enable = 1'b0;
    check_eq("rw busy", 32'(out_busy), 32'd1);
    busy_hi = 1'b1; early_r = 1'b0; wlat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_read_valid) early_r = 1'b1;
      if (out_write_valid) begin wlat = k; break; end
      busy_hi &= out_busy;
    end
    check_eq("rw wlat", 32'(wlat), 32'(Lat));
    check_eq("rw busy held", 32'(busy_hi), 32'd1);
    check_eq("rw no early read", 32'(early_r), 32'd0);
    @(posedge clk); #1;
    in_read_enable = 1'b0;
    check_eq("rw read accepted", 32'(out_busy), 32'd1);
    rlat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_read_valid) begin rlat = k; break; end
    end
    check_eq("rw rlat", 32'(rlat), 32'(Lat));
    check_eq("rw rdata", out_read_data, 32'hAAAD_BEEF);
    load(32'h1008, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("rw wrote", rd, 32'h1122_3344);

    // Reset during the wait of a store
    in_write_address = 32'h1000; in_write_data = 32'hCAFE_F00D; in_write_size = 2'd2;
    in_write_enable  = 1'b1;
    @(posedge clk); #1;
    in_write_enable = 1'b0;
    check_eq("mid busy", 32'(out_busy), 32'd1);
    reset = 1'b0;
    #2;
    check_eq("mid rst busy", 32'(out_busy), 32'd0);
    check_eq("mid rst rdata", out_read_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen_w = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_write_valid) seen_w = 1'b1;
    end
    check_eq("mid no wvalid", 32'(seen_w), 32'd0);
    check_eq("mid busy after", 32'(out_busy), 32'd0);
    load(32'h1000, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("mid word kept", rd, 32'hAAAD_BEEF);

`ifdef MEM_RESPONDER_RESERVATION_EN
    load(32'h1010, 2'd2, 1'b1, lat, rd, ex, rv);
    check_eq("lr held", 32'(rv), 32'h1);
    store(32'h1010, 32'h0101_0101, 2'd2, 1'b0, lat, ex);
    check_eq("st clears", 32'(out_read_reservation), 32'h0);
    store(32'h1010, 32'h0000_0055, 2'd2, 1'b1, lat, ex);
    check_eq("sc fail resv", 32'(out_read_reservation), 32'h2);
    check_eq("sc fail exc", 32'(ex), 32'h0);
    load(32'h1010, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("sc fail no write", rd, 32'h0101_0101);
    load(32'h1010, 2'd2, 1'b1, lat, rd, ex, rv);
    check_eq("lr2 held", 32'(rv), 32'h1);
    store(32'h1010, 32'h0000_0077, 2'd2, 1'b1, lat, ex);
    check_eq("sc ok resv", 32'(out_read_reservation), 32'h0);
    check_eq("sc ok exc", 32'(ex), 32'h0);
    load(32'h1010, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("sc ok wrote", rd, 32'h0000_0077);
`else
    load(32'h1010, 2'd2, 1'b1, lat, rd, ex, rv);
    check_eq("lr ignored", 32'(rv), 32'h0);
    store(32'h1010, 32'h0000_0066, 2'd2, 1'b1, lat, ex);
    check_eq("sc plain exc", 32'(ex), 32'h0);
    check_eq("sc plain resv", 32'(out_read_reservation), 32'h0);
    load(32'h1010, 2'd2, 1'b0, lat, rd, ex, rv);
    check_eq("sc plain wrote", rd, 32'h0000_0066);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
